// File: rtl/cone_replay_pkg.sv
// Shared types and default constants for the cone replay driver.
package cone_replay_pkg;

  localparam int          DEF_CNT_W = 16;
  localparam logic [22:0] DEF_TAPS  = 23'h420000;  // x^23 + x^18 + 1
  localparam logic [15:0] DEF_POLY  = 16'h1021;    // x^16 + x^12 + x^5 + 1

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cone_misr.sv
// Single-bit-input MISR that compacts the captured cone outputs.
module cone_misr
  import cone_replay_pkg::*;
#(
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = DEF_POLY
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              clear,
  input  logic              enable,
  input  logic              data,
  output logic [MISR_W-1:0] signature
);

  // Clear at run start, otherwise shift-and-reduce one captured bit per enable.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= {signature[MISR_W-2:0], 1'b0}
                 ^ (signature[MISR_W-1] ? POLY : '0)
                 ^ {{(MISR_W-1){1'b0}}, data};
    end
  end

endmodule

// File: rtl/cone_replay_driver.sv
// Drives LFSR vectors into an extracted combinational cone, recirculates the
// captured output through a state flop and compacts it into a MISR signature.
module cone_replay_driver
  import cone_replay_pkg::*;
#(
  parameter int                N_IN   = 23,
  parameter int                FB_IDX = 1,
  parameter logic [N_IN-1:0]   TAPS   = DEF_TAPS,
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = DEF_POLY,
  parameter int                CNT_W  = DEF_CNT_W
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  vec_count,
  input  logic [N_IN-1:0]   seed,
  output logic [N_IN-1:0]   cone_in,
  input  logic              cone_out,
  output logic              busy,
  output logic              done,
  output logic              state_q,
  output logic [MISR_W-1:0] signature
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_IN-1:0]  LFSR_ONE = {{(N_IN-1){1'b0}}, 1'b1};

  state_t            state, state_d;
  logic [N_IN-1:0]   lfsr;
  logic [CNT_W-1:0]  cnt;
  logic              load_en;
  logic              cap_en;

  // FSM state register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d = state;
    busy    = 1'b1;
    done    = 1'b0;
    load_en = 1'b0;
    cap_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load_en = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:    state_d = (cnt == '0) ? ST_DONE : ST_APPLY;
      ST_APPLY:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        cap_en  = 1'b1;
        state_d = (cnt == CNT_ONE) ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Vector generator, remaining-vector counter and recirculated state flop.
  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      lfsr    <= '0;
      cnt     <= '0;
      state_q <= 1'b0;
    end else if (load_en) begin
      lfsr    <= (seed == '0) ? LFSR_ONE : seed;
      cnt     <= vec_count;
      state_q <= 1'b0;
    end else if (cap_en) begin
      lfsr    <= {lfsr[N_IN-2:0], ^(lfsr & TAPS)};
      cnt     <= cnt - CNT_ONE;
      state_q <= cone_out;
    end
  end

  // The cone sees the LFSR except on the input the extraction cut from its flop.
  always_comb begin
    cone_in         = lfsr;
    cone_in[FB_IDX] = state_q;
  end

  cone_misr #(
    .MISR_W (MISR_W),
    .POLY   (POLY)
  ) u_misr (
    .CK        (CK),
    .RST       (RST),
    .clear     (load_en),
    .enable    (cap_en),
    .data      (cone_out),
    .signature (signature)
  );

endmodule

// File: tb/tb_cone_replay_driver.sv
// Bench for cone_replay_driver: directed table, corner sequences and random runs.
module tb_cone_replay_driver;
  timeunit 1ns;
  timeprecision 1ps;

  logic        CK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] vec_count;
  logic [22:0] seed;
  logic [22:0] cone_in;
  logic        cone_out;
  logic        busy;
  logic        done;
  logic        state_q;
  logic [15:0] signature;

  int n_cmp  = 0;
  int n_fail = 0;
  int cone_mode = 0;

  logic [22:0] seen_q[$];
  logic [22:0] exp_q[$];

  typedef struct {
    logic [22:0]       seed;
    logic [15:0]       n;
    int                mode;
    int                pulse_at;
    logic [15:0]       exp_sig;
    logic              exp_st;
    logic [22:0]       exp_idle;
    int                nv;
    logic [2:0][22:0]  v;
  } rec_t;

  rec_t tab[7];

  cone_replay_driver dut (
    .CK        (CK),
    .RST       (RST),
    .start     (start),
    .vec_count (vec_count),
    .seed      (seed),
    .cone_in   (cone_in),
    .cone_out  (cone_out),
    .busy      (busy),
    .done      (done),
    .state_q   (state_q),
    .signature (signature)
  );

  always #5 CK = ~CK;

  // Stand-in cone: tied low, tied high, or a mix of parity and an AND term.
  function automatic logic cone_fn(input logic [22:0] v, input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return (^(v & 23'h5A5A5A)) ^ (v[1] & v[7]) ^ v[22];
  endfunction

  assign cone_out = cone_fn(cone_in, cone_mode);

  // Whole-run reference: polynomial reduction for the MISR, tap parity for the LFSR.
  function automatic void model(input logic [22:0] s, input int n, input int mode,
                                output logic [15:0] sig, output logic st,
                                output logic [22:0] idle);
    logic [22:0] lf, v;
    logic [16:0] t;
    logic        o, fb;
    exp_q.delete();
    lf  = (s == 23'd0) ? 23'd1 : s;
    sig = 16'd0;
    st  = 1'b0;
    for (int k = 0; k < n; k++) begin
      v    = lf;
      v[1] = st;
      exp_q.push_back(v);
      o = cone_fn(v, mode);
      t = {sig, 1'b0};
      if (t[16]) t = t ^ 17'h11021;
      sig = t[15:0] ^ {15'd0, o};
      st  = o;
      fb  = ($countones(lf & 23'h420000) % 2) == 1;
      lf  = {lf[21:0], fb};
    end
    idle    = lf;
    idle[1] = st;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_and_check(input rec_t r, input bit use_tab);
    logic [15:0] m_sig;
    logic        m_st;
    logic [22:0] m_idle;
    int          done_cnt, done_edge, last;
    last = 2 + 2 * int'(r.n);
    model(r.seed, int'(r.n), r.mode, m_sig, m_st, m_idle);
    cone_mode = r.mode;
    seen_q.delete();
    done_cnt  = 0;
    done_edge = -1;
    @(negedge CK);
    seed = r.seed; vec_count = r.n; start = 1'b1;
    @(posedge CK);
    for (int e = 1; e <= last + 2; e++) begin
      if (e > 1) @(posedge CK);
      @(negedge CK);
      if (e == 1) start = 1'b0;
      if (e == r.pulse_at) start = 1'b1;
      if (e == r.pulse_at + 1) start = 1'b0;
      if (done) begin done_cnt++; done_edge = e; end
      if ((e % 2 == 0) && (e < last)) seen_q.push_back(cone_in);
      if (e == 1) check("busy_in_run", {31'd0, busy}, 32'd1);
      if (e == last + 1) check("busy_after_done", {31'd0, busy}, 32'd0);
    end
    check("done_count", done_cnt, 1);
    check("done_latency", done_edge, last);
    check("vector_count", seen_q.size(), exp_q.size());
    for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++)
      check("vector_model", {9'd0, seen_q[i]}, {9'd0, exp_q[i]});
    check("signature_model", {16'd0, signature}, {16'd0, m_sig});
    check("state_q_model", {31'd0, state_q}, {31'd0, m_st});
    check("idle_cone_in_model", {9'd0, cone_in}, {9'd0, m_idle});
    if (use_tab) begin
      check("signature_tab", {16'd0, signature}, {16'd0, r.exp_sig});
      check("state_q_tab", {31'd0, state_q}, {31'd0, r.exp_st});
      check("idle_cone_in_tab", {9'd0, cone_in}, {9'd0, r.exp_idle});
      for (int i = 0; i < r.nv; i++)
        if (i < seen_q.size()) check("vector_tab", {9'd0, seen_q[i]}, {9'd0, r.v[i]});
        else check("vector_tab_missing", 32'd0, 32'd1);
    end
    @(negedge CK); @(negedge CK);
    check("signature_held", {16'd0, signature}, {16'd0, m_sig});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    int   dedges[$];

    //             seed        n      md pl sig      st    idle         nv  {v2,v1,v0}
    tab[0] = '{23'h000001, 16'd0, 1, 0, 16'h0000, 1'b0, 23'h000001, 0, {23'h0, 23'h0, 23'h0}};
    tab[1] = '{23'h000001, 16'd1, 1, 0, 16'h0001, 1'b1, 23'h000002, 1, {23'h0, 23'h0, 23'h1}};
    tab[2] = '{23'h000001, 16'd2, 1, 0, 16'h0003, 1'b1, 23'h000006, 2, {23'h0, 23'h2, 23'h1}};
    tab[3] = '{23'h000000, 16'd3, 0, 0, 16'h0000, 1'b0, 23'h000008, 3, {23'h4, 23'h0, 23'h1}};
    tab[4] = '{23'h400000, 16'd1, 1, 0, 16'h0001, 1'b1, 23'h000003, 1, {23'h0, 23'h0, 23'h400000}};
    tab[5] = '{23'h7FFFFF, 16'd2, 1, 0, 16'h0003, 1'b1, 23'h7FFFFE, 2, {23'h0, 23'h7FFFFE, 23'h7FFFFD}};
    tab[6] = '{23'h000001, 16'd3, 1, 2, 16'h0007, 1'b1, 23'h00000A, 3, {23'h6, 23'h2, 23'h1}};

    RST = 1'b1; start = 1'b0; vec_count = 16'd0; seed = 23'd0;
    repeat (3) @(negedge CK);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_signature", {16'd0, signature}, 32'd0);
    check("rst_state_q", {31'd0, state_q}, 32'd0);
    check("rst_cone_in", {9'd0, cone_in}, 32'd0);
    RST = 1'b0;
    @(negedge CK);

    for (int i = 0; i < 7; i++) run_and_check(tab[i], 1'b1);

    // Reset during CAPTURE of a 5-vector run aborts with no done pulse.
    cone_mode = 2;
    @(negedge CK);
    seed = 23'h001234; vec_count = 16'd5; start = 1'b1;
    @(posedge CK);
    @(negedge CK); start = 1'b0;
    @(negedge CK);
    @(negedge CK);
    RST = 1'b1;
    #1;
    check("midrst_cone_in", {9'd0, cone_in}, 32'd0);
    check("midrst_signature", {16'd0, signature}, 32'd0);
    check("midrst_state_q", {31'd0, state_q}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge CK);
    RST = 1'b0;
    begin
      int dc;
      dc = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge CK);
        if (done) dc++;
      end
      check("midrst_no_done", dc, 0);
    end
    r = '{23'h001234, 16'd5, 2, 0, 16'h0, 1'b0, 23'h0, 0, {23'h0, 23'h0, 23'h0}};
    run_and_check(r, 1'b0);

    // Start held high through DONE launches a second run one cycle into IDLE.
    cone_mode = 1;
    dedges.delete();
    @(negedge CK);
    seed = 23'h000001; vec_count = 16'd1; start = 1'b1;
    @(posedge CK);
    for (int e = 1; e <= 12; e++) begin
      if (e > 1) @(posedge CK);
      @(negedge CK);
      if (done) dedges.push_back(e);
      if (e == 5) check("held_busy_idle", {31'd0, busy}, 32'd0);
      if (e == 6) begin
        check("held_busy_rerun", {31'd0, busy}, 32'd1);
        start = 1'b0;
      end
    end
    check("held_done_count", dedges.size(), 2);
    if (dedges.size() == 2) begin
      check("held_done_first", dedges[0], 4);
      check("held_done_second", dedges[1], 9);
    end
    check("held_signature", {16'd0, signature}, 32'd1);

    // Randomized runs against the reference model.
    for (int i = 0; i < 12; i++) begin
      r = '{23'h0, 16'd0, 2, 0, 16'h0, 1'b0, 23'h0, 0, {23'h0, 23'h0, 23'h0}};
      r.seed = 23'($urandom);
      r.n    = 16'($urandom_range(0, 12));
      if (i == 11) r.n = 16'd100;
      run_and_check(r, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
